alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational ALU between two requesters (requester 0: integer pipeline execute stage; requester 1: address/auxiliary unit) with a valid/ready handshake. Round-robin arbitration with an optional lock lets one requester issue an uninterrupted operation sequence. The block drives the ALU operand/control inputs, registers the ALU result and flags, and returns a one-cycle response pulse to the requester whose operation was accepted.

## Interface

Parameters:

- WIDTH, 32, data width of operands and result
- CTRL_WIDTH, 3, ALU control width

Ports:

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0Valid / req1Valid  in  1  request present
- req0Ready / req1Ready  out  1  request accepted this cycle when valid is also high
- req0Ctrl / req1Ctrl  in  CTRL_WIDTH  ALU operation code
- req0A, req0B / req1A, req1B  in  WIDTH  operands
- req0Lock / req1Lock  in  1  keep ownership after this operation
- rsp0Valid / rsp1Valid  out  1  one-cycle pulse: response for requester 0 / 1
- rspResult  out  WIDTH  registered ALU result
- rspCarry, rspOverflow, rspZero  out  1 each  registered ALU flags
- aluControl  out  CTRL_WIDTH  to ALU
- aluA, aluB  out  WIDTH  to ALU
- aluResult  in  WIDTH  from ALU
- aluCarry, aluOverflow, aluZero  in  1 each  from ALU

## Operation

- At most one operation is accepted per cycle. An operation is accepted when reqNValid and reqNReady are both high.
- States:
  - FREE: no owner.
  - OWN0: requester 0 holds a lock.
  - OWN1: requester 1 holds a lock.
- Grant rules:
  - FREE, one valid: grant that requester.
  - FREE, both valid: grant the requester not granted last (lastGrant register).
  - OWNn: grant only requester n. The other requester's ready stays 0 even when the ALU is idle.
- reqNReady equals the grant to requester N and is combinational from the valids, the state, and lastGrant. Ready is never high for both requesters.
- On acceptance:
  - lastGrant is set to N.
  - Next state is OWNn if reqNLock = 1, otherwise FREE.
  - An unlocked request issued while in OWNn releases ownership.
- ALU drive:
  - Granted cycle: aluControl/aluA/aluB are the granted requester's ctrl/A/B.
  - No grant: all three are driven to 0.
- Response:
  - On the accepting edge, rspResult and the three flags capture aluResult and the ALU flags.
  - rspNValid goes to 1 for the following cycle only.
  - The response registers hold their values when no operation is accepted.
- Responses carry no backpressure. Requesters sample during the pulse cycle.

## Timing

- Reset values:
  - State FREE, lastGrant = 1, so requester 0 wins the first conflict.
  - rsp0Valid = rsp1Valid = 0.
  - rspResult = 0; rspCarry, rspOverflow and rspZero = 0.
  - The ALU drive outputs are 0, since no valid is present at reset.
- Latency is 1 cycle: an operation accepted at edge k has its response valid in cycle k to k+1.
- Back-to-back operations give full throughput: one response per cycle, including alternating requesters under contention.
- Simultaneous events:
  - Both valid in FREE: round-robin applies.
  - The owner's valid low while in OWNn: no grant. The ALU is idle and the state is unchanged.
- Lock with no further request: ownership persists indefinitely. Requesters are responsible for releasing it.
- Reset asserted mid-sequence: the in-flight response is dropped, rspNValid is cleared immediately, and ownership is cleared.
- The ALU path is purely combinational within the grant cycle. The critical path is valid → grant → operand mux → ALU → response register.

## Structure

- Shared package holds:
  - state encoding: ST_FREE = 2'b00, ST_OWN0 = 2'b01, ST_OWN1 = 2'b10
  - ALU opcode constants: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, SLL 110, SRL 111
- One sub-module: rr_arbiter2.
  - Inputs: two valids, lastGrant, state.
  - Outputs: one-hot grant.
- The top level contains the state/lastGrant registers, the operand mux, and the response registers.
- The ALU is instantiated outside this block. The bench instantiates the existing ALU alongside it.

## Test plan

- Reset, then req0 only, ADD 5+7, no lock:
  - req0Ready = 1 in the same cycle.
  - Next cycle rsp0Valid = 1, rspResult = 12, zero = 0.
  - State FREE.
- Both valid in FREE after reset, ops SUB 9−9 (req0) and OR 0xF0|0x0F (req1):
  - Cycle 1 grants req0; the response has rspResult = 0, zero = 1.
  - Cycle 2 grants req1; the response has rspResult = 0xFF.
  - Holding both valid continues to alternate grants every cycle.
- req1 issues AND with lock = 1, then idles 3 cycles while req0 is valid:
  - req0Ready stays 0 for those 3 cycles.
  - req1 issues XOR with lock = 0, which is accepted.
  - req0 is granted on the next cycle.
- Overflow: req0 ADD 0x7FFFFFFF + 1:
  - rspResult = 0x80000000, rspOverflow = 1, rsp0Valid pulses for exactly 1 cycle.
  - rspResult is unchanged on the idle cycles that follow.
- Reset mid-sequence: assert rst asynchronously in the cycle after an accepted SLL 1<<4 (the response is pending):
  - rsp0Valid drops immediately and rspResult reads 0.
  - After release the state is FREE, and a contention test shows req0 wins first.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ownership state
// encoding and ALU opcode constants.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_FREE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin grant with lock ownership; purely combinational,
// so ready follows valid within the same cycle.
module rr_arbiter2
  import alu_arbiter_pkg::*;
(
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_grant_i,
  input  state_e     state_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (state_i)
      ST_FREE: begin
        if (valid0_i && valid1_i) begin
          // Conflict: favour whoever was not served last
          grant_o = last_grant_i ? 2'b01 : 2'b10;
        end else begin
          grant_o = {valid1_i, valid0_i};
        end
      end
      ST_OWN0: grant_o = {1'b0, valid0_i};
      ST_OWN1: grant_o = {valid1_i, 1'b0};
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters; registers
// the ALU result/flags and pulses a one-cycle response to the winner.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CTRL_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0Valid,
  output logic                  req0Ready,
  input  logic [CTRL_WIDTH-1:0] req0Ctrl,
  input  logic [WIDTH-1:0]      req0A,
  input  logic [WIDTH-1:0]      req0B,
  input  logic                  req0Lock,
  input  logic                  req1Valid,
  output logic                  req1Ready,
  input  logic [CTRL_WIDTH-1:0] req1Ctrl,
  input  logic [WIDTH-1:0]      req1A,
  input  logic [WIDTH-1:0]      req1B,
  input  logic                  req1Lock,
  output logic                  rsp0Valid,
  output logic                  rsp1Valid,
  output logic [WIDTH-1:0]      rspResult,
  output logic                  rspCarry,
  output logic                  rspOverflow,
  output logic                  rspZero,
  output logic [CTRL_WIDTH-1:0] aluControl,
  output logic [WIDTH-1:0]      aluA,
  output logic [WIDTH-1:0]      aluB,
  input  logic [WIDTH-1:0]      aluResult,
  input  logic                  aluCarry,
  input  logic                  aluOverflow,
  input  logic                  aluZero
);

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [1:0] grant;

  rr_arbiter2 u_rr_arbiter2 (
    .valid0_i     (req0Valid),
    .valid1_i     (req1Valid),
    .last_grant_i (last_grant_q),
    .state_i      (state_q),
    .grant_o      (grant)
  );

  assign req0Ready = grant[0];
  assign req1Ready = grant[1];

  // An accepted unlocked request always returns to FREE, even from OWNn
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (grant[0]) begin
      last_grant_d = 1'b0;
      state_d      = req0Lock ? ST_OWN0 : ST_FREE;
    end else if (grant[1]) begin
      last_grant_d = 1'b1;
      state_d      = req1Lock ? ST_OWN1 : ST_FREE;
    end
  end

  always_comb begin
    aluControl = '0;
    aluA       = '0;
    aluB       = '0;
    if (grant[0]) begin
      aluControl = req0Ctrl;
      aluA       = req0A;
      aluB       = req0B;
    end else if (grant[1]) begin
      aluControl = req1Ctrl;
      aluA       = req1A;
      aluB       = req1B;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FREE;
      last_grant_q <= 1'b1;
      rsp0Valid    <= 1'b0;
      rsp1Valid    <= 1'b0;
      rspResult    <= '0;
      rspCarry     <= 1'b0;
      rspOverflow  <= 1'b0;
      rspZero      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp0Valid    <= grant[0];
      rsp1Valid    <= grant[1];
      if (grant != 2'b00) begin
        rspResult   <= aluResult;
        rspCarry    <= aluCarry;
        rspOverflow <= aluOverflow;
        rspZero     <= aluZero;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a reference ALU sits beside the DUT and
// expected responses are queued at grant time, then popped on the response.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        o;
    logic        z;
  } alu_out_t;

  typedef struct {
    logic     who;
    alu_out_t res;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0Valid, req1Valid, req0Lock, req1Lock;
  logic        req0Ready, req1Ready;
  logic [2:0]  req0Ctrl, req1Ctrl;
  logic [31:0] req0A, req0B, req1A, req1B;
  logic        rsp0Valid, rsp1Valid;
  logic [31:0] rspResult;
  logic        rspCarry, rspOverflow, rspZero;
  logic [2:0]  aluControl;
  logic [31:0] aluA, aluB, aluResult;
  logic        aluCarry, aluOverflow, aluZero;

  int       n_tests = 0;
  int       n_fail  = 0;
  exp_t     sb[$];
  int       m_state;
  logic     m_last;
  alu_out_t held;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .CTRL_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .req0Valid(req0Valid), .req0Ready(req0Ready), .req0Ctrl(req0Ctrl),
    .req0A(req0A), .req0B(req0B), .req0Lock(req0Lock),
    .req1Valid(req1Valid), .req1Ready(req1Ready), .req1Ctrl(req1Ctrl),
    .req1A(req1A), .req1B(req1B), .req1Lock(req1Lock),
    .rsp0Valid(rsp0Valid), .rsp1Valid(rsp1Valid), .rspResult(rspResult),
    .rspCarry(rspCarry), .rspOverflow(rspOverflow), .rspZero(rspZero),
    .aluControl(aluControl), .aluA(aluA), .aluB(aluB),
    .aluResult(aluResult), .aluCarry(aluCarry),
    .aluOverflow(aluOverflow), .aluZero(aluZero)
  );

  function automatic alu_out_t alu_f(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    alu_out_t o;
    logic [32:0] wide;
    o = '{r: 32'h0, c: 1'b0, o: 1'b0, z: 1'b0};
    case (op)
      ALU_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        o.r = wide[31:0]; o.c = wide[32];
        o.o = (a[31] == b[31]) && (o.r[31] != a[31]);
      end
      ALU_SUB: begin
        wide = {1'b0, a} - {1'b0, b};
        o.r = wide[31:0]; o.c = wide[32];
        o.o = (a[31] != b[31]) && (o.r[31] != a[31]);
      end
      ALU_AND: o.r = a & b;
      ALU_OR:  o.r = a | b;
      ALU_XOR: o.r = a ^ b;
      ALU_SLT: o.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLL: o.r = a << b[4:0];
      default: o.r = a >> b[4:0];
    endcase
    o.z = (o.r == 32'h0);
    return o;
  endfunction

  // Stand-in for the existing external ALU
  always_comb begin
    alu_out_t ao;
    ao          = alu_f(aluControl, aluA, aluB);
    aluResult   = ao.r;
    aluCarry    = ao.c;
    aluOverflow = ao.o;
    aluZero     = ao.z;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_last  = 1'b1;
    held    = '{r: 32'h0, c: 1'b0, o: 1'b0, z: 1'b0};
    sb.delete();
  endtask

  task automatic check_rsp();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp0Valid", rsp0Valid, !e.who);
      chk("rsp1Valid", rsp1Valid, e.who);
      chk("rspResult", rspResult, e.res.r);
      chk("rspCarry", rspCarry, e.res.c);
      chk("rspOverflow", rspOverflow, e.res.o);
      chk("rspZero", rspZero, e.res.z);
      held = e.res;
      $display("[TB] rsp req%0d result=%08h c=%0b o=%0b z=%0b", e.who, rspResult,
               rspCarry, rspOverflow, rspZero);
    end else begin
      chk("rsp0Valid_idle", rsp0Valid, 1'b0);
      chk("rsp1Valid_idle", rsp1Valid, 1'b0);
      chk("rspResult_hold", rspResult, held.r);
      chk("rspZero_hold", rspZero, held.z);
    end
  endtask

  // One clock of stimulus: drive after negedge, check grant/ALU drive,
  // queue the expected response, then check the response after posedge.
  task automatic cyc(input logic v0, input logic [2:0] c0, input logic [31:0] a0,
                     input logic [31:0] b0, input logic l0,
                     input logic v1, input logic [2:0] c1, input logic [31:0] a1,
                     input logic [31:0] b1, input logic l1);
    logic eg0, eg1;
    @(negedge clk);
    req0Valid = v0; req0Ctrl = c0; req0A = a0; req0B = b0; req0Lock = l0;
    req1Valid = v1; req1Ctrl = c1; req1A = a1; req1B = b1; req1Lock = l1;
    #1;
    if (m_state == 1) begin
      eg0 = v0; eg1 = 1'b0;
    end else if (m_state == 2) begin
      eg0 = 1'b0; eg1 = v1;
    end else if (v0 && v1) begin
      eg0 = m_last; eg1 = !m_last;
    end else begin
      eg0 = v0; eg1 = v1;
    end
    chk("req0Ready", req0Ready, eg0);
    chk("req1Ready", req1Ready, eg1);
    chk("aluControl", aluControl, eg0 ? c0 : (eg1 ? c1 : 3'd0));
    chk("aluA", aluA, eg0 ? a0 : (eg1 ? a1 : 32'd0));
    chk("aluB", aluB, eg0 ? b0 : (eg1 ? b1 : 32'd0));
    if (eg0) begin
      sb.push_back('{who: 1'b0, res: alu_f(c0, a0, b0)});
      m_last = 1'b0; m_state = l0 ? 1 : 0;
    end else if (eg1) begin
      sb.push_back('{who: 1'b1, res: alu_f(c1, a1, b1)});
      m_last = 1'b1; m_state = l1 ? 2 : 0;
    end
    $display("[TB] drive v0=%0b v1=%0b grant0=%0b grant1=%0b", v0, v1, req0Ready, req1Ready);
    @(posedge clk);
    #1;
    check_rsp();
  endtask

  task automatic idle();
    cyc(0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0Valid = 0; req1Valid = 0; req0Lock = 0; req1Lock = 0;
    req0Ctrl = 0; req1Ctrl = 0; req0A = 0; req0B = 0; req1A = 0; req1B = 0;
    #1;
    chk("rst_rsp0Valid", rsp0Valid, 1'b0);
    chk("rst_rsp1Valid", rsp1Valid, 1'b0);
    chk("rst_rspResult", rspResult, 32'h0);
    chk("rst_flags", {rspCarry, rspOverflow, rspZero}, 3'b000);
    chk("rst_alu_drive", {aluControl, aluA, aluB}, 67'h0);
    chk("rst_ready", {req0Ready, req1Ready}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    $display("[TB] reset applied");
  endtask

  initial begin
    logic v0, v1, l0, l1;
    logic [2:0] c0, c1;
    rst = 1'b1;
    model_reset();
    do_reset();

    // Single requester ADD 5+7
    cyc(1, ALU_ADD, 32'd5, 32'd7, 0, 0, 3'd0, 0, 0, 0);
    chk("add_result", rspResult, 32'd12);
    chk("add_zero", rspZero, 1'b0);
    idle();

    // Contention after reset: req0 first, then strict alternation
    do_reset();
    cyc(1, ALU_SUB, 32'd9, 32'd9, 0, 1, ALU_OR, 32'hF0, 32'h0F, 0);
    chk("sub_result", rspResult, 32'h0);
    chk("sub_zero", rspZero, 1'b1);
    chk("sub_rsp0", rsp0Valid, 1'b1);
    cyc(1, ALU_SUB, 32'd9, 32'd9, 0, 1, ALU_OR, 32'hF0, 32'h0F, 0);
    chk("or_result", rspResult, 32'hFF);
    chk("or_rsp1", rsp1Valid, 1'b1);
    for (int i = 0; i < 4; i++)
      cyc(1, ALU_SUB, 32'd20, i, 0, 1, ALU_XOR, 32'hAA, i, 0);

    // Lock held by req1 blocks req0 until an unlocked req1 op
    do_reset();
    cyc(0, 3'd0, 0, 0, 0, 1, ALU_AND, 32'hFF00, 32'h0FF0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, ALU_ADD, 32'd1, 32'd2, 0, 0, 3'd0, 0, 0, 0);
      chk("lock_block_ready0", req0Ready, 1'b0);
    end
    cyc(1, ALU_ADD, 32'd1, 32'd2, 0, 1, ALU_XOR, 32'h1234, 32'h1234, 0);
    chk("xor_rsp1", rsp1Valid, 1'b1);
    cyc(1, ALU_ADD, 32'd1, 32'd2, 0, 1, ALU_XOR, 32'h5, 32'h3, 0);
    chk("after_release_rsp0", rsp0Valid, 1'b1);

    // Signed overflow, then hold on idle cycles
    do_reset();
    cyc(1, ALU_ADD, 32'h7FFFFFFF, 32'd1, 0, 0, 3'd0, 0, 0, 0);
    chk("ovf_result", rspResult, 32'h80000000);
    chk("ovf_flag", rspOverflow, 1'b1);
    idle();
    chk("ovf_pulse_end", rsp0Valid, 1'b0);
    idle();

    // Randomised mix of valids, locks and opcodes
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
      l0 = ($urandom_range(0, 3) == 0); l1 = ($urandom_range(0, 3) == 0);
      c0 = 3'($urandom_range(0, 7)); c1 = 3'($urandom_range(0, 7));
      cyc(v0, c0, $urandom, $urandom, l0, v1, c1, $urandom, $urandom, l1);
    end

    // Asynchronous reset while a response is being presented
    do_reset();
    cyc(1, ALU_SLL, 32'd1, 32'd4, 1, 0, 3'd0, 0, 0, 0);
    chk("sll_result", rspResult, 32'd16);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_rsp0Valid", rsp0Valid, 1'b0);
    chk("midrst_rspResult", rspResult, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc(1, ALU_ADD, 32'd3, 32'd4, 0, 1, ALU_SUB, 32'd3, 32'd4, 0);
    chk("post_rst_req0_first", rsp0Valid, 1'b1);
    cyc(1, ALU_ADD, 32'd3, 32'd4, 0, 1, ALU_SUB, 32'd3, 32'd4, 0);
    chk("post_rst_req1_next", rsp1Valid, 1'b1);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
